// File: rtl/decode_stage_hs.sv
// RV32I/M decode stage with valid/ready handshake on both sides.
// Holds on backpressure, inserts one bubble on load-use, and counts bubbles (saturating).
module decode_stage_hs #(
  parameter int unsigned XLEN     = 32,
  parameter bit          ENABLE_M = 1'b1,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [XLEN-1:0]  pc_i,
  input  logic [XLEN-1:0]  inst_i,
  input  logic             if_valid_i,
  output logic             id_ready_o,
  input  logic [XLEN-1:0]  reg_data1_i,
  input  logic [XLEN-1:0]  reg_data2_i,
  output logic [4:0]       rs1_addr_o,
  output logic [4:0]       rs2_addr_o,
  input  logic             flush_i,
  input  logic             ex_ready_i,
  output logic             ex_valid_o,
  output logic [XLEN-1:0]  pc_o,
  output logic [XLEN-1:0]  imm_o,
  output logic [XLEN-1:0]  rs1_o,
  output logic [XLEN-1:0]  rs2_o,
  output logic [4:0]       rd_addr_o,
  output logic [4:0]       fwd_raddr1_o,
  output logic [4:0]       fwd_raddr2_o,
  output logic             rd_we_o,
  output logic             mem_re_o,
  output logic             mem_we_o,
  output logic             shiftsel_o,
  output logic             addsubsel_o,
  output logic             jtypesel_o,
  output logic [2:0]       opfunc3_o,
  output logic [3:0]       optype_o,
  output logic             illegal_o,
  output logic             loaduse_hazard_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  localparam logic [3:0] OptR     = 4'd0;
  localparam logic [3:0] OptI     = 4'd1;
  localparam logic [3:0] OptB     = 4'd2;
  localparam logic [3:0] OptS     = 4'd3;
  localparam logic [3:0] OptLui   = 4'd4;
  localparam logic [3:0] OptAuipc = 4'd5;
  localparam logic [3:0] OptJump  = 4'd6;
  localparam logic [3:0] OptLoad  = 4'd7;
  localparam logic [3:0] OptMul   = 4'd8;
  localparam logic [3:0] OptIll   = 4'd15;

  logic [6:0]      w_opcode, w_funct7;
  logic [2:0]      w_funct3;
  logic [4:0]      w_rd, w_rs1, w_rs2;
  logic [3:0]      w_optype;
  logic [XLEN-1:0] w_imm;
  logic            w_use1, w_use2, w_wr;
  logic            w_can_adv, w_hazard;

  logic             r_valid, r_rd_we, r_mem_re, r_mem_we, r_shift, r_addsub, r_jtype, r_ill;
  logic [XLEN-1:0]  r_pc, r_imm, r_rs1, r_rs2;
  logic [4:0]       r_rd, r_ra1, r_ra2;
  logic [2:0]       r_f3;
  logic [3:0]       r_optype;
  logic [CNT_W-1:0] r_cnt;

  assign w_opcode = inst_i[6:0];
  assign w_rd     = inst_i[11:7];
  assign w_funct3 = inst_i[14:12];
  assign w_rs1    = inst_i[19:15];
  assign w_rs2    = inst_i[24:20];
  assign w_funct7 = inst_i[31:25];

  always_comb begin
    w_optype = OptIll;
    w_imm    = '0;
    w_use1   = 1'b0;
    w_use2   = 1'b0;
    w_wr     = 1'b0;
    case (w_opcode)
      7'b0110011: begin
        // funct7 0000001 is MULDIV; without the M extension it decodes as illegal
        if (w_funct7 == 7'b0000001) begin
          if (ENABLE_M) begin
            w_optype = OptMul;
            w_use1   = 1'b1;
            w_use2   = 1'b1;
            w_wr     = 1'b1;
          end
        end else begin
          w_optype = OptR;
          w_use1   = 1'b1;
          w_use2   = 1'b1;
          w_wr     = 1'b1;
        end
      end
      7'b0010011: begin
        w_optype = OptI;
        w_imm    = {{20{inst_i[31]}}, inst_i[31:20]};
        w_use1   = 1'b1;
        w_wr     = 1'b1;
      end
      7'b0000011: begin
        w_optype = OptLoad;
        w_imm    = {{20{inst_i[31]}}, inst_i[31:20]};
        w_use1   = 1'b1;
        w_wr     = 1'b1;
      end
      7'b0100011: begin
        w_optype = OptS;
        w_imm    = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
        w_use1   = 1'b1;
        w_use2   = 1'b1;
      end
      7'b1100011: begin
        w_optype = OptB;
        w_imm    = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
        w_use1   = 1'b1;
        w_use2   = 1'b1;
      end
      7'b0110111: begin
        w_optype = OptLui;
        w_imm    = {inst_i[31:12], 12'b0};
        w_wr     = 1'b1;
      end
      7'b0010111: begin
        w_optype = OptAuipc;
        w_imm    = {inst_i[31:12], 12'b0};
        w_wr     = 1'b1;
      end
      7'b1101111: begin
        w_optype = OptJump;
        w_imm    = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
        w_wr     = 1'b1;
      end
      7'b1100111: begin
        w_optype = OptJump;
        w_imm    = {{20{inst_i[31]}}, inst_i[31:20]};
        w_use1   = 1'b1;
        w_wr     = 1'b1;
      end
      default: ;
    endcase
  end

  assign w_hazard = if_valid_i & r_valid & r_mem_re & (r_rd != 5'd0) &
                    ((w_use1 & (w_rs1 == r_rd)) | (w_use2 & (w_rs2 == r_rd)));
  assign w_can_adv = ~r_valid | ex_ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_valid <= 1'b0; r_rd_we <= 1'b0; r_mem_re <= 1'b0; r_mem_we <= 1'b0;
      r_shift <= 1'b0; r_addsub <= 1'b0; r_jtype <= 1'b0; r_ill <= 1'b0;
      r_f3 <= '0; r_optype <= '0; r_cnt <= '0;
      r_pc <= '0; r_imm <= '0; r_rs1 <= '0; r_rs2 <= '0;
      r_rd <= '0; r_ra1 <= '0; r_ra2 <= '0;
    end else if (flush_i || (w_can_adv && (w_hazard || !if_valid_i))) begin
      // Flush, load-use bubble and idle all leave an invalid, control-free slot
      r_valid <= 1'b0; r_rd_we <= 1'b0; r_mem_re <= 1'b0; r_mem_we <= 1'b0;
      r_shift <= 1'b0; r_addsub <= 1'b0; r_jtype <= 1'b0; r_ill <= 1'b0;
      r_f3 <= '0; r_optype <= '0;
      if (!flush_i && w_hazard && (r_cnt != '1)) r_cnt <= r_cnt + CNT_W'(1);
    end else if (w_can_adv) begin
      r_valid  <= 1'b1;
      r_rd_we  <= w_wr & (w_rd != 5'd0);
      r_mem_re <= (w_optype == OptLoad);
      r_mem_we <= (w_optype == OptS);
      r_shift  <= (w_funct7 == 7'b0100000);
      r_addsub <= (w_optype == OptR) & (w_funct7 == 7'b0100000) & (w_funct3 == 3'b000);
      r_jtype  <= (w_opcode == 7'b1101111);
      r_ill    <= (w_optype == OptIll);
      r_f3     <= (w_optype == OptLui) ? 3'b000 : w_funct3;
      r_optype <= w_optype;
      r_pc     <= pc_i;
      r_imm    <= w_imm;
      r_rs1    <= reg_data1_i;
      r_rs2    <= reg_data2_i;
      r_rd     <= w_rd;
      r_ra1    <= w_rs1;
      r_ra2    <= w_rs2;
    end
  end

  assign id_ready_o       = flush_i | (w_can_adv & ~w_hazard);
  assign loaduse_hazard_o = w_hazard;
  assign rs1_addr_o       = w_rs1;
  assign rs2_addr_o       = w_rs2;
  assign ex_valid_o       = r_valid;
  assign pc_o             = r_pc;
  assign imm_o            = r_imm;
  assign rs1_o            = r_rs1;
  assign rs2_o            = r_rs2;
  assign rd_addr_o        = r_rd;
  assign fwd_raddr1_o     = r_ra1;
  assign fwd_raddr2_o     = r_ra2;
  assign rd_we_o          = r_rd_we;
  assign mem_re_o         = r_mem_re;
  assign mem_we_o         = r_mem_we;
  assign shiftsel_o       = r_shift;
  assign addsubsel_o      = r_addsub;
  assign jtypesel_o       = r_jtype;
  assign opfunc3_o        = r_f3;
  assign optype_o         = r_optype;
  assign illegal_o        = r_ill;
  assign stall_cnt_o      = r_cnt;

endmodule

// File: tb/tb_decode_stage_hs.sv
// Bench for decode_stage_hs: vector table through a scoreboard plus hand-written handshake cases.
// A second instance (no M extension, 2-bit counter) shares all inputs.
module tb_decode_stage_hs;

  localparam int CW = 192;

  typedef struct {
    logic [31:0] inst;
    logic [3:0]  optype;
    logic [31:0] imm;
    logic [2:0]  f3;
    logic [6:0]  ctrl;  // {rd_we, mem_re, mem_we, shift, addsub, jtype, illegal}
    logic [31:0] pc;
    logic [31:0] d1;
    logic [31:0] d2;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1, if_valid_i = 1'b0, flush_i = 1'b0, ex_ready_i = 1'b1;
  logic [31:0] pc_i = '0, inst_i = '0, reg_data1_i = '0, reg_data2_i = '0;

  logic        id_ready, ex_valid, rd_we, mem_re, mem_we, shiftsel, addsubsel, jtypesel;
  logic        illegal, hazard;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr, fwd1, fwd2;
  logic [31:0] pc_o, imm_o, rs1_o, rs2_o;
  logic [2:0]  opfunc3;
  logic [3:0]  optype;
  logic [15:0] stall_cnt;

  logic        m_id_ready, m_ex_valid, m_rd_we, m_mem_re, m_mem_we, m_shiftsel, m_addsubsel;
  logic        m_jtypesel, m_illegal, m_hazard;
  logic [4:0]  m_rs1_addr, m_rs2_addr, m_rd_addr, m_fwd1, m_fwd2;
  logic [31:0] m_pc_o, m_imm_o, m_rs1_o, m_rs2_o;
  logic [2:0]  m_opfunc3;
  logic [3:0]  m_optype;
  logic [1:0]  m_stall_cnt;

  always #5 clk = ~clk;

  decode_stage_hs #(.XLEN(32), .ENABLE_M(1'b1), .CNT_W(16)) dut (
    .clk_i(clk), .rst_i(rst_i), .pc_i(pc_i), .inst_i(inst_i), .if_valid_i(if_valid_i),
    .id_ready_o(id_ready), .reg_data1_i(reg_data1_i), .reg_data2_i(reg_data2_i),
    .rs1_addr_o(rs1_addr), .rs2_addr_o(rs2_addr), .flush_i(flush_i), .ex_ready_i(ex_ready_i),
    .ex_valid_o(ex_valid), .pc_o(pc_o), .imm_o(imm_o), .rs1_o(rs1_o), .rs2_o(rs2_o),
    .rd_addr_o(rd_addr), .fwd_raddr1_o(fwd1), .fwd_raddr2_o(fwd2), .rd_we_o(rd_we),
    .mem_re_o(mem_re), .mem_we_o(mem_we), .shiftsel_o(shiftsel), .addsubsel_o(addsubsel),
    .jtypesel_o(jtypesel), .opfunc3_o(opfunc3), .optype_o(optype), .illegal_o(illegal),
    .loaduse_hazard_o(hazard), .stall_cnt_o(stall_cnt)
  );

  decode_stage_hs #(.XLEN(32), .ENABLE_M(1'b0), .CNT_W(2)) dut_nom (
    .clk_i(clk), .rst_i(rst_i), .pc_i(pc_i), .inst_i(inst_i), .if_valid_i(if_valid_i),
    .id_ready_o(m_id_ready), .reg_data1_i(reg_data1_i), .reg_data2_i(reg_data2_i),
    .rs1_addr_o(m_rs1_addr), .rs2_addr_o(m_rs2_addr), .flush_i(flush_i),
    .ex_ready_i(ex_ready_i), .ex_valid_o(m_ex_valid), .pc_o(m_pc_o), .imm_o(m_imm_o),
    .rs1_o(m_rs1_o), .rs2_o(m_rs2_o), .rd_addr_o(m_rd_addr), .fwd_raddr1_o(m_fwd1),
    .fwd_raddr2_o(m_fwd2), .rd_we_o(m_rd_we), .mem_re_o(m_mem_re), .mem_we_o(m_mem_we),
    .shiftsel_o(m_shiftsel), .addsubsel_o(m_addsubsel), .jtypesel_o(m_jtypesel),
    .opfunc3_o(m_opfunc3), .optype_o(m_optype), .illegal_o(m_illegal),
    .loaduse_hazard_o(m_hazard), .stall_cnt_o(m_stall_cnt)
  );

  logic [CW-1:0] w_snap;
  assign w_snap = CW'({ex_valid, pc_o, imm_o, rs1_o, rs2_o, rd_addr, fwd1, fwd2, rd_we, mem_re,
                       mem_we, shiftsel, addsubsel, jtypesel, opfunc3, optype, illegal,
                       stall_cnt});

  int          n_chk = 0, n_fail = 0;
  vec_t        sb[$];
  vec_t        cur;
  vec_t        tbl[14];
  logic [31:0] pc_ctr = 32'h1000;

  function automatic vec_t mk(input logic [31:0] inst, input logic [3:0] opt,
                              input logic [31:0] imm, input logic [2:0] f3,
                              input logic [6:0] ctrl);
    vec_t v;
    v.inst = inst; v.optype = opt; v.imm = imm; v.f3 = f3; v.ctrl = ctrl;
    v.pc = '0; v.d1 = '0; v.d2 = '0;
    return v;
  endfunction

  task automatic chk(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic present(input vec_t v, input logic valid, input logic [31:0] d1);
    cur = v;
    cur.pc = pc_ctr;
    cur.d1 = d1;
    cur.d2 = $urandom;
    inst_i = v.inst; pc_i = cur.pc; reg_data1_i = d1; reg_data2_i = cur.d2;
    if_valid_i = valid;
    pc_ctr += 4;
  endtask

  // Negedge sample: retire/compare the ID/EX slot, then record a newly accepted instruction
  task automatic sample();
    vec_t e;
    @(negedge clk);
    if (rst_i) begin
      sb.delete();
    end else begin
      if (ex_valid) begin
        if (sb.size() == 0) begin
          chk("sb_unexpected_valid", CW'(1), CW'(0));
        end else if (flush_i) begin
          void'(sb.pop_front());
        end else if (ex_ready_i) begin
          e = sb.pop_front();
          chk("optype", CW'(optype), CW'(e.optype));
          chk("imm", CW'(imm_o), CW'(e.imm));
          chk("ctrl_f3", CW'({rd_we, mem_re, mem_we, shiftsel, addsubsel, jtypesel, illegal,
                              opfunc3}), CW'({e.ctrl, e.f3}));
          chk("pc_ops", CW'({pc_o, rs1_o, rs2_o}), CW'({e.pc, e.d1, e.d2}));
          chk("addrs", CW'({rd_addr, fwd1, fwd2}),
              CW'({e.inst[11:7], e.inst[19:15], e.inst[24:20]}));
        end
      end
      if (if_valid_i && id_ready && !flush_i) sb.push_back(cur);
    end
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    present(mk(32'h0, 4'd0, 32'h0, 3'd0, 7'h0), 1'b0, 32'h0);
  endtask

  // Load then dependent add: one bubble, then the add takes the re-sampled operand
  task automatic load_use(input logic [31:0] ld, input logic [31:0] add, input logic stall);
    logic [31:0] d_new;
    d_new = $urandom;
    present(mk(ld, 4'd7, 32'h0, 3'd2, {(ld[11:7] != 5'd0), 6'b100000}), 1'b1, $urandom);
    sample(); chk("lu_load_accept", CW'(id_ready), CW'(1)); advance();
    present(mk(add, 4'd0, 32'h0, 3'd0, 7'b1000000), 1'b1, $urandom);
    sample();
    chk("lu_hazard", CW'(hazard), CW'(stall));
    chk("lu_id_ready", CW'(id_ready), CW'(!stall));
    advance();
    if (stall) begin
      present(mk(add, 4'd0, 32'h0, 3'd0, 7'b1000000), 1'b1, d_new);
      sample();
      chk("lu_bubble_valid", CW'(ex_valid), CW'(0));
      chk("lu_retry_ready", CW'(id_ready), CW'(1));
      advance();
    end
    idle(); sample(); advance();
  endtask

  initial begin
    tbl[0]  = mk(32'h00500093, 4'd1,  32'h00000005, 3'd0, 7'b1000000); // addi x1,x0,5
    tbl[1]  = mk(32'h00108133, 4'd0,  32'h00000000, 3'd0, 7'b1000000); // add x2,x1,x1
    tbl[2]  = mk(32'h402081B3, 4'd0,  32'h00000000, 3'd0, 7'b1001100); // sub x3,x1,x2
    tbl[3]  = mk(32'h0020A423, 4'd3,  32'h00000008, 3'd2, 7'b0010000); // sw x2,8(x1)
    tbl[4]  = mk(32'hFE208EE3, 4'd2,  32'hFFFFFFFC, 3'd0, 7'b0000000); // beq x1,x2,-4
    tbl[5]  = mk(32'h123452B7, 4'd4,  32'h12345000, 3'd0, 7'b1000000); // lui x5
    tbl[6]  = mk(32'h00001317, 4'd5,  32'h00001000, 3'd1, 7'b1000000); // auipc x6,1
    tbl[7]  = mk(32'h008000EF, 4'd6,  32'h00000008, 3'd0, 7'b1000010); // jal x1,8
    tbl[8]  = mk(32'h00408067, 4'd6,  32'h00000004, 3'd0, 7'b0000000); // jalr x0,4(x1)
    tbl[9]  = mk(32'h02208033, 4'd8,  32'h00000000, 3'd0, 7'b0000000); // mul x0,x1,x2
    tbl[10] = mk(32'h022083B3, 4'd8,  32'h00000000, 3'd0, 7'b1000000); // mul x7,x1,x2
    tbl[11] = mk(32'h4030D213, 4'd1,  32'h00000403, 3'd5, 7'b1001000); // srai x4,x1,3
    tbl[12] = mk(32'hFFC12483, 4'd7,  32'hFFFFFFFC, 3'd2, 7'b1100000); // lw x9,-4(x2)
    tbl[13] = mk(32'h00000FFF, 4'd15, 32'h00000000, 3'd0, 7'b0000001); // opcode 1111111

    // Reset state
    advance(); advance();
    rst_i = 1'b0; idle();
    sample();
    chk("rst_ex_valid", CW'({ex_valid, m_ex_valid}), CW'(0));
    chk("rst_id_ready", CW'(id_ready), CW'(1));
    chk("rst_ctrl", CW'({rd_we, mem_re, mem_we, illegal, optype, stall_cnt, m_stall_cnt}),
        CW'(0));
    advance();

    // Back-to-back table stream, one instruction per cycle
    foreach (tbl[i]) begin
      present(tbl[i], 1'b1, $urandom);
      sample();
      chk("stream_accept", CW'(id_ready), CW'(1));
      if (i > 0) chk("stream_valid", CW'(ex_valid), CW'(1));
      advance();
    end
    idle(); sample(); advance();
    sample(); chk("stream_drained", CW'(ex_valid), CW'(0)); advance();

    // Load-use with a real dependency, then with rd = x0
    load_use(32'h0000A283, 32'h00028333, 1'b1);
    chk("lu_stall_cnt", CW'(stall_cnt), CW'(1));
    load_use(32'h0000A003, 32'h00000333, 1'b0);
    chk("lu_x0_stall_cnt", CW'(stall_cnt), CW'(1));

    // Backpressure: hold for three cycles, then release
    present(tbl[0], 1'b1, $urandom); sample(); advance();
    present(tbl[1], 1'b1, $urandom);
    ex_ready_i = 1'b0;
    sample();
    begin
      logic [CW-1:0] snap;
      snap = w_snap;
      chk("bp_valid", CW'(ex_valid), CW'(1));
      chk("bp_id_ready", CW'(id_ready), CW'(0));
      advance();
      for (int k = 0; k < 2; k++) begin
        sample();
        chk("bp_stable", w_snap, snap);
        chk("bp_id_ready", CW'(id_ready), CW'(0));
        advance();
      end
    end
    ex_ready_i = 1'b1;
    sample(); chk("bp_release_ready", CW'(id_ready), CW'(1)); advance();
    idle(); sample(); chk("bp_issue_next", CW'(ex_valid), CW'(1)); advance();

    // Hazard while held (no count), then flush over a held load
    present(mk(32'h0000A283, 4'd7, 32'h0, 3'd2, 7'b1100000), 1'b1, $urandom);
    sample(); advance();
    present(mk(32'h00028333, 4'd0, 32'h0, 3'd0, 7'b1000000), 1'b1, $urandom);
    ex_ready_i = 1'b0;
    sample();
    chk("held_hazard", CW'(hazard), CW'(1));
    chk("held_id_ready", CW'(id_ready), CW'(0));
    advance();
    flush_i = 1'b1;
    sample();
    chk("held_no_count", CW'(stall_cnt), CW'(1));
    chk("flush_id_ready", CW'(id_ready), CW'(1));
    advance();
    flush_i = 1'b0; ex_ready_i = 1'b1; idle();
    sample();
    chk("flush_cleared", CW'({ex_valid, mem_re, rd_we}), CW'(0));
    advance();

    // MUL without the M extension decodes as illegal but still valid
    present(tbl[9], 1'b1, $urandom); sample(); advance();
    idle();
    sample();
    chk("nom_mul_optype", CW'({m_optype, m_illegal}), CW'({4'd15, 1'b1}));
    chk("nom_mul_valid_en", CW'({m_ex_valid, m_rd_we, m_mem_re, m_mem_we}), CW'(4'b1000));
    advance();

    // Five more load-use stalls: 16-bit counter reaches 6, 2-bit counter pins at 3
    for (int k = 0; k < 5; k++) load_use(32'h0000A283, 32'h00028333, 1'b1);
    chk("sat_cnt16", CW'(stall_cnt), CW'(6));
    chk("sat_cnt2", CW'(m_stall_cnt), CW'(3));

    // Reset mid-stream
    present(tbl[0], 1'b1, $urandom); sample(); advance();
    present(tbl[1], 1'b1, $urandom);
    rst_i = 1'b1;
    sample(); advance();
    rst_i = 1'b0; idle();
    sample();
    chk("midrst_state", CW'({ex_valid, id_ready, stall_cnt, m_stall_cnt}),
        CW'({1'b0, 1'b1, 16'd0, 2'd0}));
    advance();

    chk("sb_empty", CW'(sb.size()), CW'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
